// File: rtl/mini_alu_pkg.sv
// Shared opcode, FSM-state and instruction-field definitions for the mini ALU core.
package mini_alu_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_MUL  = 4'd3,
    OP_STO  = 4'd4,
    OP_BLE  = 4'd5,
    OP_JMP  = 4'd6,
    OP_LCD  = 4'd7,
    OP_SHR  = 4'd8,
    OP_CALL = 4'd9,
    OP_RET  = 4'd10
  } opcode_e;

  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_LCD_SETUP = 3'd1,
    ST_LCD_PULSE = 3'd2,
    ST_LCD_HOLD  = 3'd3,
    ST_HALT      = 3'd4
  } state_e;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] dest;
    logic [7:0] src1;
    logic [7:0] src0;
  } instr_t;

endpackage

// File: rtl/mini_alu_stack.sv
// Return-address stack: DEPTH entries of W bits, top of stack visible on data_o.
module mini_alu_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] sp_q, sp_d;
  logic [AW-1:0] wr_idx, rd_idx;

  assign full_o  = (sp_q == PW'(DEPTH));
  assign empty_o = (sp_q == '0);
  assign wr_idx  = AW'(sp_q);
  assign rd_idx  = AW'(sp_q - 1'b1);
  assign data_o  = empty_o ? '0 : mem_q[rd_idx];

  always_comb begin
    sp_d = sp_q;
    if (push_i && !full_o)
      sp_d = sp_q + 1'b1;
    else if (pop_i && !empty_o)
      sp_d = sp_q - 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sp_q <= '0;
    else       sp_q <= sp_d;
  end

  // Entry storage needs no reset: the pointer alone defines what is valid.
  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) mem_q[wr_idx] <= data_i;
  end

endmodule

// File: rtl/mini_alu_core.sv
// Single-cycle 28-bit-instruction ALU core with register file, return stack and
// a 4-bit LCD write sequencer (setup / E pulse / hold).
module mini_alu_core
  import mini_alu_pkg::*;
#(
  parameter int DATA_W        = 16,
  parameter int IP_W          = 16,
  parameter int NUM_REGS      = 32,
  parameter int STACK_DEPTH   = 4,
  parameter int LCD_EN_CYCLES = 12
) (
  input  logic            Clock,
  input  logic            Reset,
  output logic [IP_W-1:0] oIP,
  input  logic [27:0]     iInstruction,
  output logic [3:0]      oLCD,
  output logic            oRegisterSelect,
  output logic            oEnable,
  output logic            oReadWrite,
  output logic            oHalted,
  output logic            oStackErr
);

  localparam int RA_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int CNT_W = $clog2(LCD_EN_CYCLES + 1);

  function automatic logic [RA_W-1:0] reg_addr(input logic [7:0] field);
    return RA_W'(int'(field) % NUM_REGS);
  endfunction

  instr_t            ins;
  state_e            state_q, state_d;
  logic [IP_W-1:0]   ip_q, ip_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        lcd_q, lcd_d;
  logic              rs_q, rs_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rf_q [NUM_REGS];
  logic [DATA_W-1:0] op_a, op_b, wdata;
  logic              we, push, pop, stk_full, stk_empty;
  logic [IP_W-1:0]   stk_top;

  assign ins  = instr_t'(iInstruction);
  assign op_a = rf_q[reg_addr(ins.src1)];
  assign op_b = rf_q[reg_addr(ins.src0)];

  mini_alu_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (IP_W)
  ) u_stack (
    .clk_i   (Clock),
    .rst_i   (Reset),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (ip_q + 1'b1),
    .data_o  (stk_top),
    .full_o  (stk_full),
    .empty_o (stk_empty)
  );

  always_comb begin
    state_d = state_q;
    ip_d    = ip_q;
    cnt_d   = cnt_q;
    lcd_d   = lcd_q;
    rs_d    = rs_q;
    err_d   = err_q;
    we      = 1'b0;
    wdata   = '0;
    push    = 1'b0;
    pop     = 1'b0;
    case (state_q)
      ST_RUN: begin
        ip_d = ip_q + 1'b1;
        case (ins.op)
          OP_NOP: ;
          OP_ADD: begin we = 1'b1; wdata = op_a + op_b; end
          OP_SUB: begin we = 1'b1; wdata = op_a - op_b; end
          OP_MUL: begin we = 1'b1; wdata = op_a * op_b; end
          OP_STO: begin we = 1'b1; wdata = DATA_W'({ins.src1, ins.src0}); end
          OP_BLE: if ($signed(op_a) <= $signed(op_b)) ip_d = IP_W'(ins.dest);
          OP_JMP: ip_d = IP_W'(ins.dest);
          OP_SHR: begin
            we    = 1'b1;
            wdata = (op_b >= DATA_W'(DATA_W)) ? '0 : (op_a >> op_b);
          end
          OP_CALL: begin
            if (stk_full) begin
              state_d = ST_HALT;
              err_d   = 1'b1;
              ip_d    = ip_q;
            end else begin
              push = 1'b1;
              ip_d = IP_W'(ins.dest);
            end
          end
          OP_RET: begin
            if (stk_empty) begin
              state_d = ST_HALT;
              err_d   = 1'b1;
              ip_d    = ip_q;
            end else begin
              pop  = 1'b1;
              ip_d = stk_top;
            end
          end
          OP_LCD: begin
            lcd_d   = op_a[3:0];
            rs_d    = op_b[0];
            state_d = ST_LCD_SETUP;
            ip_d    = ip_q;
          end
          default: begin
            state_d = ST_HALT;
            ip_d    = ip_q;
          end
        endcase
      end
      ST_LCD_SETUP: begin
        state_d = ST_LCD_PULSE;
        cnt_d   = '0;
      end
      // E stays high for LCD_EN_CYCLES clocks, counted 0..LCD_EN_CYCLES-1.
      ST_LCD_PULSE: begin
        if (cnt_q == CNT_W'(LCD_EN_CYCLES - 1)) state_d = ST_LCD_HOLD;
        else                                    cnt_d   = cnt_q + 1'b1;
      end
      ST_LCD_HOLD: begin
        state_d = ST_RUN;
        ip_d    = ip_q + 1'b1;
      end
      ST_HALT: ;
      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_RUN;
      ip_q    <= '0;
      cnt_q   <= '0;
      lcd_q   <= '0;
      rs_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ip_q    <= ip_d;
      cnt_q   <= cnt_d;
      lcd_q   <= lcd_d;
      rs_q    <= rs_d;
      err_q   <= err_d;
    end
  end

  // Register file is left unreset; software initialises it with STO.
  always_ff @(posedge Clock) begin
    if (we) rf_q[reg_addr(ins.dest)] <= wdata;
  end

  assign oIP             = ip_q;
  assign oLCD            = lcd_q;
  assign oRegisterSelect = rs_q;
  assign oEnable         = (state_q == ST_LCD_PULSE);
  assign oReadWrite      = 1'b0;
  assign oHalted         = (state_q == ST_HALT);
  assign oStackErr       = err_q;

endmodule

// File: tb/tb_mini_alu_core.sv
// Directed bench for mini_alu_core: instructions are driven straight onto
// iInstruction each cycle and results checked against hand-computed values.
module tb_mini_alu_core;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] oIP;
  logic [27:0] iInstruction;
  logic [3:0]  oLCD;
  logic        oRegisterSelect, oEnable, oReadWrite, oHalted, oStackErr;

  int n_tests = 0;
  int n_fail  = 0;

  mini_alu_core dut (
    .Clock           (Clock),
    .Reset           (Reset),
    .oIP             (oIP),
    .iInstruction    (iInstruction),
    .oLCD            (oLCD),
    .oRegisterSelect (oRegisterSelect),
    .oEnable         (oEnable),
    .oReadWrite      (oReadWrite),
    .oHalted         (oHalted),
    .oStackErr       (oStackErr)
  );

  always #5 Clock = ~Clock;

  function automatic logic [27:0] ins(input logic [3:0] op, input logic [7:0] d,
                                      input logic [7:0] s1, input logic [7:0] s0);
    return {op, d, s1, s0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic exec(input logic [27:0] i);
    iInstruction = i;
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    iInstruction = '0;
    @(posedge Clock);
    #1;
    Reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e_cnt, e_first, e_last, ip_k;
    Reset        = 1'b1;
    iInstruction = '0;
    repeat (2) @(posedge Clock);
    #1;
    check("rst_ip",     32'(oIP), 32'h0);
    check("rst_lcd",    32'(oLCD), 32'h0);
    check("rst_rs",     32'(oRegisterSelect), 32'h0);
    check("rst_en",     32'(oEnable), 32'h0);
    check("rst_rw",     32'(oReadWrite), 32'h0);
    check("rst_halt",   32'(oHalted), 32'h0);
    check("rst_err",    32'(oStackErr), 32'h0);
    Reset = 1'b0;

    // Arithmetic: STO / SUB / ADD overflow / MUL / SHR
    exec(ins(4'd4, 8'd1, 8'h00, 8'h07));
    exec(ins(4'd4, 8'd2, 8'h00, 8'h05));
    exec(ins(4'd2, 8'd3, 8'd1, 8'd2));
    check("sub_r3",  32'(dut.rf_q[3]), 32'h2);
    check("sub_ip",  32'(oIP), 32'h3);
    exec(ins(4'd4, 8'd4, 8'h7F, 8'hFF));
    exec(ins(4'd4, 8'd5, 8'h00, 8'h01));
    exec(ins(4'd1, 8'd6, 8'd4, 8'd5));
    check("add_wrap", 32'(dut.rf_q[6]), 32'h8000);
    exec(ins(4'd3, 8'd8, 8'd1, 8'd2));
    check("mul_r8",  32'(dut.rf_q[8]), 32'h23);
    exec(ins(4'd8, 8'd9, 8'd4, 8'd5));
    check("shr_1",   32'(dut.rf_q[9]), 32'h3FFF);
    exec(ins(4'd4, 8'd10, 8'h00, 8'h10));
    exec(ins(4'd8, 8'd11, 8'd4, 8'd10));
    check("shr_16",  32'(dut.rf_q[11]), 32'h0);
    exec(ins(4'd4, 8'd33, 8'h12, 8'h34));
    check("reg_mod", 32'(dut.rf_q[1]), 32'h1234);
    check("ip_seq",  32'(oIP), 32'hB);
    exec(ins(4'd4, 8'd1, 8'h00, 8'h07));

    // Signed BLE: -3 <= 2 taken, 2 <= -3 falls through
    exec(ins(4'd4, 8'd12, 8'hFF, 8'hFD));
    exec(ins(4'd4, 8'd13, 8'h00, 8'h02));
    exec(ins(4'd5, 8'h40, 8'd12, 8'd13));
    check("ble_taken", 32'(oIP), 32'h40);
    exec(ins(4'd5, 8'h80, 8'd13, 8'd12));
    check("ble_not",   32'(oIP), 32'h41);
    exec(ins(4'd6, 8'h20, 8'd0, 8'd0));
    check("jmp",       32'(oIP), 32'h20);

    // LCD write sequence
    exec(ins(4'd4, 8'd14, 8'h00, 8'hA5));
    exec(ins(4'd4, 8'd15, 8'h00, 8'h01));
    exec(ins(4'd7, 8'd0, 8'd14, 8'd15));
    check("lcd_data",  32'(oLCD), 32'h5);
    check("lcd_rs",    32'(oRegisterSelect), 32'h1);
    check("lcd_setup_e", 32'(oEnable), 32'h0);
    check("lcd_ip_hold", 32'(oIP), 32'h22);
    e_cnt = 0; e_first = -1; e_last = -1; ip_k = -1;
    iInstruction = '0;
    for (int k = 1; k <= 14; k++) begin
      @(posedge Clock);
      #1;
      if (oEnable) begin
        e_cnt++;
        if (e_first < 0) e_first = k;
        e_last = k;
      end
      if (ip_k < 0 && oIP != 16'h22) ip_k = k;
    end
    check("lcd_e_cnt",   32'(e_cnt), 32'd12);
    check("lcd_e_first", 32'(e_first), 32'd1);
    check("lcd_e_last",  32'(e_last), 32'd12);
    check("lcd_ip_k",    32'(ip_k), 32'd14);
    check("lcd_ip_new",  32'(oIP), 32'h23);
    check("lcd_data_kept", 32'({oLCD, oRegisterSelect}), 32'hB);

    // Nested CALL x4 / RET x4, then overflow on a 5th CALL
    exec(ins(4'd9, 8'h30, 8'd0, 8'd0));
    exec(ins(4'd9, 8'h40, 8'd0, 8'd0));
    exec(ins(4'd9, 8'h50, 8'd0, 8'd0));
    exec(ins(4'd9, 8'h60, 8'd0, 8'd0));
    check("call4_ip", 32'(oIP), 32'h60);
    exec(ins(4'd10, 8'd0, 8'd0, 8'd0));
    check("ret1", 32'(oIP), 32'h51);
    exec(ins(4'd10, 8'd0, 8'd0, 8'd0));
    check("ret2", 32'(oIP), 32'h41);
    exec(ins(4'd10, 8'd0, 8'd0, 8'd0));
    check("ret3", 32'(oIP), 32'h31);
    exec(ins(4'd10, 8'd0, 8'd0, 8'd0));
    check("ret4", 32'(oIP), 32'h24);
    check("ret_err", 32'(oStackErr), 32'h0);
    exec(ins(4'd9, 8'h30, 8'd0, 8'd0));
    exec(ins(4'd9, 8'h40, 8'd0, 8'd0));
    exec(ins(4'd9, 8'h50, 8'd0, 8'd0));
    exec(ins(4'd9, 8'h60, 8'd0, 8'd0));
    exec(ins(4'd9, 8'h70, 8'd0, 8'd0));
    check("ovf_halt", 32'(oHalted), 32'h1);
    check("ovf_err",  32'(oStackErr), 32'h1);
    check("ovf_ip",   32'(oIP), 32'h60);
    exec(ins(4'd4, 8'd1, 8'h00, 8'h99));
    exec(ins(4'd7, 8'd0, 8'd14, 8'd15));
    check("halt_ip",  32'(oIP), 32'h60);
    check("halt_nowr", 32'(dut.rf_q[1]), 32'h7);
    check("halt_en",  32'(oEnable), 32'h0);

    // RET on empty stack
    do_reset();
    check("rst2_clear", 32'({oHalted, oStackErr, oIP}), 32'h0);
    exec(ins(4'd10, 8'd0, 8'd0, 8'd0));
    check("uf_halt", 32'(oHalted), 32'h1);
    check("uf_err",  32'(oStackErr), 32'h1);
    check("uf_ip",   32'(oIP), 32'h0);

    // Illegal opcode halts without flagging a stack error
    do_reset();
    exec(ins(4'd0, 8'd0, 8'd0, 8'd0));
    exec(ins(4'd15, 8'd0, 8'd0, 8'd0));
    check("ill_halt", 32'(oHalted), 32'h1);
    check("ill_err",  32'(oStackErr), 32'h0);
    check("ill_ip",   32'(oIP), 32'h1);
    exec(ins(4'd0, 8'd0, 8'd0, 8'd0));
    check("ill_frozen", 32'(oIP), 32'h1);

    // Asynchronous reset in the middle of the E pulse
    do_reset();
    exec(ins(4'd0, 8'd0, 8'd0, 8'd0));
    exec(ins(4'd7, 8'd0, 8'd14, 8'd15));
    iInstruction = '0;
    repeat (3) @(posedge Clock);
    #1;
    check("pulse_e", 32'(oEnable), 32'h1);
    #2;
    Reset = 1'b1;
    #1;
    check("async_e",   32'(oEnable), 32'h0);
    check("async_ip",  32'(oIP), 32'h0);
    check("async_lcd", 32'({oLCD, oRegisterSelect}), 32'h0);
    @(posedge Clock);
    #3;
    Reset = 1'b0;
    exec(ins(4'd0, 8'd0, 8'd0, 8'd0));
    check("resume_ip", 32'(oIP), 32'h1);
    check("resume_e",  32'(oEnable), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
